// File: rtl/reg_stage_pkg.sv
// ============================================================================
// reg_stage_pkg : state encoding shared by the register-stage family
// Rev 1.0
// ============================================================================
`default_nettype none

package reg_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/skid_stage_if.sv
// ============================================================================
// skid_stage_if : valid/ready handshake bundle around a skid stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface skid_stage_if #(
  parameter type DATA_T = logic
);
  logic  valid_src;
  logic  ready_src;
  DATA_T src;
  logic  valid_dst;
  logic  ready_dst;
  DATA_T dst;

  // master: the surrounding logic (producer and consumer); slave: the stage
  modport master (
    output valid_src, src, ready_dst,
    input  ready_src, valid_dst, dst
  );

  modport slave (
    input  valid_src, src, ready_dst,
    output ready_src, valid_dst, dst
  );
endinterface

`default_nettype wire

// File: rtl/sat_cnt_m.sv
// ============================================================================
// sat_cnt_m : counter with increment, synchronous clear and wrap/saturate select
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_cnt_m #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             sat,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_hold;

  assign w_hold = sat && (r_cnt == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && !w_hold) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/skid_stage_m.sv
// ============================================================================
// skid_stage_m : fully registered two-entry valid/ready stage (ready cut)
// Optional statistics counters enabled by macro SKID_STAGE_STATS_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module skid_stage_m
  import reg_stage_pkg::*;
#(
  parameter type DATA_T = logic,
  parameter int  CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  skid_stage_if.slave      bus
`ifdef SKID_STAGE_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  skid_state_t r_state;
  skid_state_t w_state_nxt;
  logic        r_rdy_en;
  DATA_T       r_main;
  DATA_T       r_skid;

  logic w_valid;
  logic w_ready;
  logic w_in_hs;
  logic w_out_hs;
  logic w_ld_main_src;
  logic w_ld_main_skid;
  logic w_ld_skid;

  // r_rdy_en keeps ready_src low for the cycle following a reset edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_in_hs) w_state_nxt = BUSY;
      BUSY: begin
        if (w_in_hs && !w_out_hs)      w_state_nxt = FULL;
        else if (!w_in_hs && w_out_hs) w_state_nxt = EMPTY;
      end
      FULL:    if (w_out_hs) w_state_nxt = BUSY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Load enables are written from state and raw inputs to avoid a loop through ready_src
  always_comb begin
    w_valid        = (r_state == BUSY) || (r_state == FULL);
    w_ready        = r_rdy_en && (r_state != FULL);
    w_ld_main_src  = bus.valid_src && r_rdy_en &&
                     ((r_state == EMPTY) || ((r_state == BUSY) && bus.ready_dst));
    w_ld_main_skid = (r_state == FULL) && bus.ready_dst;
    w_ld_skid      = (r_state == BUSY) && bus.valid_src && r_rdy_en && !bus.ready_dst;
  end

  assign w_in_hs  = bus.valid_src && w_ready;
  assign w_out_hs = w_valid && bus.ready_dst;

  always_ff @(posedge clk) begin
    if (w_ld_main_src) begin
      r_main <= bus.src;
    end else if (w_ld_main_skid) begin
      r_main <= r_skid;
    end
    if (w_ld_skid) begin
      r_skid <= bus.src;
    end
  end

  assign bus.valid_dst = w_valid;
  assign bus.ready_src = w_ready;
  assign bus.dst       = r_main;

`ifdef SKID_STAGE_STATS_EN
  sat_cnt_m #(.WIDTH(CNT_W)) u_xfer_cnt (
    .clk (clk),
    .clr (stats_clr),
    .inc (w_out_hs),
    .sat (1'b0),
    .cnt (xfer_cnt)
  );

  sat_cnt_m #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (stats_clr),
    .inc (w_valid && !bus.ready_dst),
    .sat (1'b1),
    .cnt (stall_cnt)
  );
`endif

endmodule

`default_nettype wire
